// File: rtl/img_crop_if.sv
// BRAM and handshake bundle for the crop pass.
//   crop_start     : level request to start a pass (environment -> crop)
//   crop_completed : pass finished, held until crop_start drops
//   ren / wen      : single-port BRAM read / write enables
//   addr           : 17-bit BRAM address
//   din / dout     : BRAM write data / read data
//   crop_checksum  : running sum of written pixels (zero when the feature is off)
// Modport master is taken by the crop block, slave by the BRAM/controller side.
interface img_crop_if;
  logic        crop_start;
  logic        crop_completed;
  logic        ren;
  logic        wen;
  logic [16:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [23:0] crop_checksum;

  modport master (
    input  crop_start, dout,
    output crop_completed, ren, wen, addr, din, crop_checksum
  );

  modport slave (
    output crop_start, dout,
    input  crop_completed, ren, wen, addr, din, crop_checksum
  );
endinterface

// File: rtl/img_crop.sv
// img_crop: copies the central IMG_WIDTH x IMG_HEIGHT window of a padded image held in BRAM
// (padded width IMG_WIDTH + 2*PAD_SIZE, origin SRC_BASE) to a compact image at DST_BASE.
// One pixel costs RD_LAT+2 cycles: RD (ren), RD_LAT WAIT cycles, WR (wen).
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : img_crop_if.master (crop_start/crop_completed handshake, BRAM ren/wen/addr/din/dout,
//            crop_checksum)
//
// Optional feature: define IMG_CROP_CHECKSUM_EN to accumulate the written pixels into
// crop_checksum (cleared at pass start, stable from DONE until the next start). Without it
// crop_checksum is tied to zero and no accumulator exists.
module img_crop #(
  parameter int unsigned IMG_WIDTH  = 150,
  parameter int unsigned IMG_HEIGHT = 150,
  parameter int unsigned PAD_SIZE   = 22,
  parameter int unsigned SRC_BASE   = 22500,
  parameter int unsigned DST_BASE   = 60136,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  img_crop_if.master  bus
);

  localparam int unsigned PW     = IMG_WIDTH + 2 * PAD_SIZE;
  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned WaitW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  // Elaboration-time constants only; the datapath itself is purely incremental.
  localparam logic [16:0]      SrcStart = 17'(SRC_BASE + PAD_SIZE * PW + PAD_SIZE);
  localparam logic [16:0]      DstStart = 17'(DST_BASE);
  localparam logic [16:0]      RowSkip  = 17'(2 * PAD_SIZE + 1);
  localparam logic [ColW-1:0]  ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(IMG_HEIGHT - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_LAT - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [16:0]       src_q, src_d;
  logic [16:0]       dst_q, dst_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [16:0]       addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              done_q, done_d;

  logic              last_pix;
  assign last_pix = (col_q == ColLast) && (row_q == RowLast);

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    col_d   = col_q;
    row_d   = row_q;
    wait_d  = wait_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.crop_start) begin
          src_d   = SrcStart;
          dst_d   = DstStart;
          col_d   = '0;
          row_d   = '0;
          state_d = StRd;
          ren_d   = 1'b1;
          addr_d  = SrcStart;
        end
      end
      StRd: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          // dout is valid in this last WAIT cycle.
          din_d   = bus.dout;
          wen_d   = 1'b1;
          addr_d  = dst_q;
          state_d = StWr;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWr: begin
        dst_d = dst_q + 17'd1;
        if (col_q != ColLast) begin
          col_d = col_q + ColW'(1);
          src_d = src_q + 17'd1;
        end else begin
          // Jump over the right pad of this row and the left pad of the next.
          col_d = '0;
          row_d = row_q + RowW'(1);
          src_d = src_q + RowSkip;
        end
        if (last_pix) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StRd;
          ren_d   = 1'b1;
          addr_d  = src_d;
        end
      end
      StDone: begin
        // Stay here while start is still high so a held request does not rerun.
        if (!bus.crop_start) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wait_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wait_q  <= wait_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  assign bus.ren            = ren_q;
  assign bus.wen            = wen_q;
  assign bus.addr           = addr_q;
  assign bus.din            = din_q;
  assign bus.crop_completed = done_q;

`ifdef IMG_CROP_CHECKSUM_EN
  logic [23:0] sum_q;

  // Adds the pixel being written during its WR cycle; cleared when a pass starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (state_q == StIdle && bus.crop_start) begin
      sum_q <= '0;
    end else if (state_q == StWr) begin
      sum_q <= sum_q + {16'd0, din_q};
    end
  end

  assign bus.crop_checksum = sum_q;
`else
  assign bus.crop_checksum = '0;
`endif

endmodule

// File: tb/tb_img_crop.sv
// Self-checking bench for img_crop on a small geometry (5x4 image, 2-pixel pad, RD_LAT 2).
// A BRAM model serves reads from img[]; the expected bus activity of every cycle of a pass is
// derived from pixel index arithmetic (RD at 1+4i, WR at 4+4i, DONE at 4N+1).
module tb_img_crop;

  localparam int unsigned TW    = 5;
  localparam int unsigned TH    = 4;
  localparam int unsigned TP    = 2;
  localparam int unsigned TSRC  = 100;
  localparam int unsigned TDST  = 1000;
  localparam int unsigned TLAT  = 2;
  localparam int unsigned TPW   = TW + 2 * TP;
  localparam int unsigned NPIX  = TW * TH;
  localparam int unsigned PER   = TLAT + 2;
  localparam int unsigned DONEK = PER * NPIX + 1;

  logic clk;
  logic rst_n;
  img_crop_if bus ();

  img_crop #(
    .IMG_WIDTH (TW),
    .IMG_HEIGHT(TH),
    .PAD_SIZE  (TP),
    .SRC_BASE  (TSRC),
    .DST_BASE  (TDST),
    .RD_LAT    (TLAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read data appears TLAT cycles after the ren cycle.
  logic [7:0] img [0:2047];
  logic [7:0] rd_p [0:TLAT-1];

  always @(posedge clk) begin
    if (bus.ren) rd_p[0] <= img[bus.addr[10:0]];
    for (int j = 1; j < TLAT; j++) rd_p[j] <= rd_p[j-1];
  end
  assign bus.dout = rd_p[TLAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  int obs_done_k, obs_rd4, obs_rd5, obs_wr0_addr, obs_wr0_din, obs_wrl_addr, obs_wrl_din;
  int obs_sum_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mode 0: (pr+pc)&255 pattern, 1: random, 2: constant 0x5A. Surroundings always random.
  task automatic fill(input int mode);
    for (int a = 0; a < 2048; a++) img[a] = 8'($urandom);
    for (int pr = 0; pr < TH + 2 * TP; pr++)
      for (int pc = 0; pc < TPW; pc++) begin
        if (mode == 0) img[TSRC + pr * TPW + pc] = 8'((pr + pc) & 255);
        else if (mode == 2) img[TSRC + pr * TPW + pc] = 8'h5a;
      end
  endtask

  task automatic check_idle(input string tag, input logic [23:0] exp_sum);
    check({tag, "_ren"}, 32'(bus.ren), 0);
    check({tag, "_wen"}, 32'(bus.wen), 0);
    check({tag, "_done"}, 32'(bus.crop_completed), 0);
    check({tag, "_sum"}, 32'(bus.crop_checksum), 32'(exp_sum));
  endtask

  // Asynchronous reset in the middle of a clock's low phase, then a few idle cycles.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    bus.crop_start = 1'b0;
    #1;
    check("rst_ren", 32'(bus.ren), 0);
    check("rst_wen", 32'(bus.wen), 0);
    check("rst_done", 32'(bus.crop_completed), 0);
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_din", 32'(bus.din), 0);
    check("rst_sum", 32'(bus.crop_checksum), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("post_rst", 24'd0);
    end
  endtask

  // One pass. hold_done: cycles crop_completed stays high (start held). toggle: random start
  // during the busy part. abort_at: cycle at which reset is asserted (0 = never).
  task automatic run_pass(input int hold_done, input bit toggle, input int abort_at);
    logic [23:0] exp_sum;
    int i, ph, r, c, s, d;
    bit e_ren, e_wen, e_done;
    exp_sum = '0;
    obs_done_k = -1;
    @(negedge clk);
    bus.crop_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= DONEK + hold_done + 3; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        do_reset();
        return;
      end
      e_ren = 1'b0;
      e_wen = 1'b0;
      e_done = (k >= DONEK) && (k < DONEK + hold_done);
      s = 0;
      if (k <= PER * NPIX) begin
        i  = (k - 1) / PER;
        ph = (k - 1) % PER;
        r  = i / TW;
        c  = i % TW;
        s  = TSRC + (r + TP) * TPW + c + TP;
        d  = TDST + i;
        if (ph == 0) begin
          e_ren = 1'b1;
          check("rd_addr", 32'(bus.addr), 32'(s));
          if (i == 4) obs_rd4 = int'(bus.addr);
          if (i == 5) obs_rd5 = int'(bus.addr);
        end else if (ph == PER - 1) begin
          e_wen = 1'b1;
          check("wr_addr", 32'(bus.addr), 32'(d));
          check("wr_din", 32'(bus.din), 32'(img[s]));
          if (i == 0) begin
            obs_wr0_addr = int'(bus.addr);
            obs_wr0_din  = int'(bus.din);
          end
          if (i == NPIX - 1) begin
            obs_wrl_addr = int'(bus.addr);
            obs_wrl_din  = int'(bus.din);
          end
        end
      end
      check("ren", 32'(bus.ren), 32'(e_ren));
      check("wen", 32'(bus.wen), 32'(e_wen));
      check("completed", 32'(bus.crop_completed), 32'(e_done));
`ifdef IMG_CROP_CHECKSUM_EN
      check("checksum", 32'(bus.crop_checksum), 32'(exp_sum));
`else
      check("checksum", 32'(bus.crop_checksum), 0);
`endif
      if (obs_done_k < 0 && bus.crop_completed === 1'b1) obs_done_k = k;
      if (k == DONEK) obs_sum_done = int'(bus.crop_checksum);
      if (e_wen) exp_sum = exp_sum + 24'(img[s]);
      // Drive start for the edge that closes this cycle.
      if (k >= DONEK - 1 && k < DONEK + hold_done - 1) bus.crop_start = 1'b1;
      else if (k < DONEK - 1 && toggle) bus.crop_start = 1'($urandom_range(0, 1));
      else bus.crop_start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.crop_start = 1'b0;
    for (int j = 0; j < 2048; j++) img[j] = '0;
    #3;
    check("init_ren", 32'(bus.ren), 0);
    check("init_wen", 32'(bus.wen), 0);
    check("init_done", 32'(bus.crop_completed), 0);
    check("init_addr", 32'(bus.addr), 0);
    check("init_din", 32'(bus.din), 0);
    check("init_sum", 32'(bus.crop_checksum), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle", 24'd0);
    end

    // Pattern image: pin the model with hand-computed values.
    fill(0);
    run_pass(1, 1'b0, 0);
    check("lit_first_din", 32'(obs_wr0_din), 4);
    check("lit_first_addr", 32'(obs_wr0_addr), 1000);
    check("lit_last_din", 32'(obs_wrl_din), 11);
    check("lit_last_addr", 32'(obs_wrl_addr), 1019);
    check("lit_rd_row_end", 32'(obs_rd4), 124);
    check("lit_rd_row_skip", 32'(obs_rd5), 129);
    check("lit_done_cycle", 32'(obs_done_k), 81);

    // Random image, start toggled while busy.
    fill(1);
    run_pass(1, 1'b1, 0);

    // Constant image, start held through DONE, then rerun with identical results.
    fill(2);
    run_pass(6, 1'b0, 0);
`ifdef IMG_CROP_CHECKSUM_EN
    check("lit_checksum_5a", 32'(obs_sum_done), 1800);
`else
    check("lit_checksum_5a", 32'(obs_sum_done), 0);
`endif
    run_pass(3, 1'b1, 0);

    // Reset mid-pass, then a fresh pass.
    fill(1);
    run_pass(1, 1'b0, 50);
    run_pass(2, 1'b0, 0);
    fill(1);
    run_pass(4, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/img_crop.md
# img_crop

Inverse of the padding stage: reads the processed padded image from BRAM and writes the central `IMG_WIDTH`×`IMG_HEIGHT` region back as a compact, unpadded image. It strips `PAD_SIZE` rows and columns from every edge. It is the last BRAM pass of the local-contrast pipeline, run after windowed processing, and drives the shared single-port BRAM through the same `ren`/`wen`/`addr`/`din`/`dout` signals and start/completed handshake as the other passes.

## Interface
- `IMG_WIDTH`, 150, width of the output image in pixels.
- `IMG_HEIGHT`, 150, height of the output image in pixels.
- `PAD_SIZE`, 22, padding border width on each side.
- `SRC_BASE`, 22500, BRAM address of padded pixel (0,0); padded width `PW = IMG_WIDTH + 2*PAD_SIZE`.
- `DST_BASE`, 60136, BRAM address of output pixel (0,0).
- `RD_LAT`, 2, cycles from the `ren` cycle until `dout` is valid (≥1).

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `crop_start` in 1: level request to start the pass.
- `crop_completed` out 1: pass finished.
- `dout` in 8: BRAM read data.
- `ren` out 1: BRAM read enable.
- `wen` out 1: BRAM write enable.
- `addr` out 17: BRAM address.
- `din` out 8: BRAM write data.
- `crop_checksum` out 24: sum of written pixels (see Configuration).

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE: `ren`=`wen`=0 and `crop_completed`=0. When `crop_start`=1 is sampled:
  - load `src_ptr = SRC_BASE + PAD_SIZE*PW + PAD_SIZE` (26790 with defaults) and `dst_ptr = DST_BASE`;
  - clear the column and row counters and `crop_checksum`;
  - go to RD.
- RD, one cycle: `ren`=1, `wen`=0, `addr`=`src_ptr`. Go to WAIT.
- WAIT, `RD_LAT` cycles: `ren`=`wen`=0. In the last WAIT cycle `dout` is valid; it is captured at that cycle's closing edge.
- WR, one cycle: `wen`=1, `ren`=0, `addr`=`dst_ptr`, `din` = captured pixel. Pointer and counter update at the closing edge:
  - `dst_ptr` += 1.
  - If col < `IMG_WIDTH`-1: col += 1, `src_ptr` += 1.
  - Otherwise: col = 0, row += 1, `src_ptr` += `2*PAD_SIZE+1` (45).
  - Next state is RD, or DONE after pixel `IMG_WIDTH*IMG_HEIGHT`-1.
- DONE: `crop_completed`=1, `ren`=`wen`=0. Held until `crop_start`=0 is sampled, then return to IDLE with `crop_completed` cleared.
- Arithmetic: all pointers 17-bit unsigned, computed incrementally with no multipliers. The last source address is 55845 and the last destination address is 82635 with defaults; neither overflows.
- `crop_start` is ignored in RD/WAIT/WR; there is no restart mid-pass.
- `crop_start` held high through DONE: the block stays in DONE and does not rerun until `crop_start` drops and rises again.

## Timing
- Reset (async assert, sync release):
  - state IDLE;
  - `ren`, `wen`, `crop_completed` = 0;
  - `addr` = 0, `din` = 0, `crop_checksum` = 0.
- Reset mid-pass aborts immediately; partial output in BRAM is left as is.
- All outputs are registered.
- `crop_start` sampled at edge 0 → first RD cycle is cycle 1.
- Per pixel: RD_LAT+2 cycles, so 4 with defaults.
- Pixel i: RD at cycle 1+4i, WR at cycle 4+4i.
- Last WR at cycle 90000; `crop_completed` first high in cycle 90001.
- `ren` and `wen` are never high in the same cycle. Each is one cycle wide.

## Configuration
- `IMG_CROP_CHECKSUM_EN` defined:
  - each WR adds `din` zero-extended into `crop_checksum` (24-bit, cannot overflow: max 5,737,500);
  - the value is stable from DONE until the next start.
- Not defined: no accumulator is synthesized and `crop_checksum` is tied to 0.

## Test plan
- BRAM model with RD_LAT=2, padded region filled with `(pr+pc)&255`, start pulse held 1 cycle:
  - output[0] = 44 at address 60136;
  - output[22499] = 86 at address 82635;
  - `crop_completed` first high in cycle 90001.
- Address trace: RD addresses are 26790…26939, then 26984 (row skip of 45). WR addresses run 60136…82635 contiguous. No address outside these ranges.
- Constant padded image 0x5A with `IMG_CROP_CHECKSUM_EN`: `crop_checksum` = 2,025,000 at DONE. Same image without the macro: `crop_checksum` = 0 throughout.
- `crop_start` held high through DONE, then pulsed again: only one pass until `crop_start` drops. The second rising start reruns the pass with identical output and the checksum cleared at start.
- `rst_n` asserted at cycle 5000:
  - outputs go to 0 the same cycle, with no clock edge needed;
  - after release the block stays in IDLE until `crop_start`;
  - a fresh pass completes correctly.
- Handshake checks: `crop_start` toggled mid-pass has no effect. `ren`&`wen` is never 1 in any cycle.
